// File: rtl/row_sel_driver_if.sv
// Request handshake between the array controller and the row-select driver.
// The controller owns valid/addr; the driver owns ready.
interface row_sel_driver_if #(
  parameter int AW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/row_sel_driver.sv
// Row-select driver: sequences one wordline access (setup, enable pulse, recovery).
// Define ROW_SEL_DRV_READBACK_EN to add the decoder output check (row_out / rb_err).
//
// state | meaning
// IDLE  | ready for a request, row_sel all VSS, enable low
// SETUP | row_sel driven from the latched address, enable low
// PULSE | enable high, row_sel frozen
// RECOV | enable low, row_sel still held; done pulses on exit
module row_sel_driver #(
  parameter  int ROWS      = 16,
  parameter  int SETUP_CYC = 1,
  parameter  int PULSE_CYC = 2,
  parameter  int RECOV_CYC = 1,
  localparam int AW        = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  row_sel_driver_if.slave req,
  output real             row_sel [0:AW-1],
  output logic            enable,
  output logic            busy,
  output logic            done,
  output logic            addr_err
`ifdef ROW_SEL_DRV_READBACK_EN
  ,
  input  real             row_out [0:ROWS-1],
  output logic            rb_err
`endif
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
`ifdef ROW_SEL_DRV_READBACK_EN
  localparam real VTH = 0.8;
`endif

  localparam int CMAX = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > RECOV_CYC) ? SETUP_CYC : RECOV_CYC)
                        : ((PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC);
  localparam int CW = (CMAX + 1 > 1) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] RECOV_LAST = CW'(RECOV_CYC - 1);

  if (ROWS < 2 || SETUP_CYC < 1 || PULSE_CYC < 1 || RECOV_CYC < 1) begin : g_bad_param
    $error("row_sel_driver: ROWS must be >= 2 and every *_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    RECOV = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic          addr_ok;

  assign req.req_ready = (state == IDLE);
  assign addr_ok       = int'(req.req_addr) < ROWS;

  // addr_q is zero outside an access, so row_sel falls back to VSS without extra gating
  always_comb begin
    for (int i = 0; i < AW; i++) begin
      row_sel[i] = addr_q[i] ? VDD : VSS;
    end
  end

`ifdef ROW_SEL_DRV_READBACK_EN
  logic rb_fail;

  always_comb begin
    rb_fail = 1'b0;
    for (int j = 0; j < ROWS; j++) begin
      if (j == int'(addr_q)) begin
        if (row_out[j] < VTH) rb_fail = 1'b1;
      end else if (row_out[j] >= VTH) begin
        rb_fail = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
`ifdef ROW_SEL_DRV_READBACK_EN
      rb_err   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            if (addr_ok) begin
              state  <= SETUP;
              cnt    <= '0;
              addr_q <= req.req_addr;
              busy   <= 1'b1;
`ifdef ROW_SEL_DRV_READBACK_EN
              rb_err <= 1'b0;
`endif
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state  <= PULSE;
            cnt    <= '0;
            enable <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            state  <= RECOV;
            cnt    <= '0;
            enable <= 1'b0;
`ifdef ROW_SEL_DRV_READBACK_EN
            if (rb_fail) rb_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOV: begin
          if (cnt == RECOV_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          addr_q <= '0;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_sel_driver.sv
// Directed bench for row_sel_driver: a ROWS=16 instance for the access sequencing and a
// ROWS=10 instance for address range rejection.
module tb_row_sel_driver;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  row_sel_driver_if #(.AW(4)) ifa ();
  row_sel_driver_if #(.AW(4)) ifb ();

  real  rs_a [0:3];
  real  rs_b [0:3];
  logic en_a, busy_a, done_a, aerr_a;
  logic en_b, busy_b, done_b, aerr_b;

`ifdef ROW_SEL_DRV_READBACK_EN
  real  ro_a [0:15];
  real  ro_b [0:9];
  logic rb_a, rb_b;
  logic rb_inject = 1'b0;
  int   cur_a = 0;

  // decoder model: selected row high while enable is high, optionally with a stray row 9
  always_comb begin
    for (int j = 0; j < 16; j++)
      ro_a[j] = (en_a && (j == cur_a || (rb_inject && j == 9))) ? VDD : VSS;
    for (int j = 0; j < 10; j++) ro_b[j] = VSS;
  end
`endif

  row_sel_driver #(.ROWS(16)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (ifa),
    .row_sel  (rs_a),
    .enable   (en_a),
    .busy     (busy_a),
    .done     (done_a),
    .addr_err (aerr_a)
`ifdef ROW_SEL_DRV_READBACK_EN
    ,
    .row_out  (ro_a),
    .rb_err   (rb_a)
`endif
  );

  row_sel_driver #(.ROWS(10)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (ifb),
    .row_sel  (rs_b),
    .enable   (en_b),
    .busy     (busy_b),
    .done     (done_b),
    .addr_err (aerr_b)
`ifdef ROW_SEL_DRV_READBACK_EN
    ,
    .row_out  (ro_b),
    .rb_err   (rb_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pat[i] = 1 means row_sel[i] must be VDD, else VSS
  task automatic chk_sel(input string tag, input logic [3:0] pat);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (rs_a[i] != (pat[i] ? VDD : VSS)) ok = 1'b0;
    checks++;
    assert (ok)
    else begin
      errors++;
      $error("FAIL %s observed idx0..3=%0.1f,%0.1f,%0.1f,%0.1f expected bits idx3..0=%b",
             tag, rs_a[0], rs_a[1], rs_a[2], rs_a[3], pat);
    end
  endtask

  // row_sel must never move while enable is high, either side of the change
  real  prev_rs [0:3];
  logic prev_en;
  logic prev_ok = 1'b0;
  logic chg;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      chg = 1'b0;
      for (int i = 0; i < 4; i++) if (rs_a[i] != prev_rs[i]) chg = 1'b1;
      if (prev_ok && chg) begin
        checks++;
        assert (!(en_a || prev_en))
        else begin
          errors++;
          $error("FAIL row_sel_glitch observed enable=%0b/%0b expected 0/0", prev_en, en_a);
        end
      end
      for (int i = 0; i < 4; i++) prev_rs[i] = rs_a[i];
      prev_en = en_a;
      prev_ok = 1'b1;
    end
  end

  initial begin
    rst_n         = 1'b1;
    ifa.req_valid = 1'b0;
    ifa.req_addr  = '0;
    ifb.req_valid = 1'b0;
    ifb.req_addr  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_enable", en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr_err", aerr_a, 0);
    chk_sel("rst_row_sel", 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);
    chk("ready_after_rst", ifa.req_ready, 1);

    // single access, addr 5 accepted at T
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd5;
    cyc(1);
    ifa.req_valid = 1'b0;
    chk("t0_busy", busy_a, 1);
    chk("t0_ready", ifa.req_ready, 0);
    chk("t0_enable", en_a, 0);
    chk_sel("t0_row_sel", 4'b0101);
    cyc(1); chk("t1_enable", en_a, 1);
    cyc(1); chk("t2_enable", en_a, 1); chk_sel("t2_row_sel", 4'b0101);
    cyc(1); chk("t3_enable", en_a, 0); chk("t3_done", done_a, 0); chk_sel("t3_row_sel", 4'b0101);
    cyc(1); chk("t4_done", done_a, 1); chk_sel("t4_row_sel", 4'b0000);
    chk("t4_busy", busy_a, 0); chk("t4_ready", ifa.req_ready, 1);
    cyc(1); chk("t5_done", done_a, 0);

    // reset while enable is high
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd5;
    cyc(1);
    ifa.req_valid = 1'b0;
    cyc(1); chk("mid_enable_before", en_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_enable", en_a, 0);
    chk_sel("mid_rst_row_sel", 4'b0000);
    chk("mid_rst_busy", busy_a, 0);
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(1); chk("mid_ready_after", ifa.req_ready, 1); chk("mid_done_after", done_a, 0);
    cyc(4); chk("mid_done_later", done_a, 0); chk("mid_enable_later", en_a, 0);

    // back-to-back: 3 then 12 presented in the done cycle
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd3;
    cyc(1);
    ifa.req_valid = 1'b0;
    chk_sel("b2b_first", 4'b0011);
    cyc(4); chk("b2b_done1", done_a, 1);
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd12;
    cyc(1);
    ifa.req_valid = 1'b0;
    chk("b2b_busy2", busy_a, 1);
    chk_sel("b2b_second", 4'b1100);
    cyc(1); chk("b2b_enable2", en_a, 1);
    cyc(3); chk("b2b_done2", done_a, 1);

    // request held while busy
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd1;
    cyc(1);
    ifa.req_addr = 4'd7;
    chk_sel("held_first", 4'b0001);
    cyc(1); chk("held_ready_t1", ifa.req_ready, 0);
    cyc(2); chk_sel("held_t3_row_sel", 4'b0001);
    cyc(1); chk("held_done", done_a, 1); chk("held_ready_done", ifa.req_ready, 1);
    cyc(1);
    ifa.req_valid = 1'b0;
    chk_sel("held_accept", 4'b0111);
    chk("held_busy", busy_a, 1);
    cyc(4); chk("held_done2", done_a, 1);

    // out-of-range on the ROWS=10 instance
    ifb.req_valid = 1'b1; ifb.req_addr = 4'd12;
    cyc(1);
    ifb.req_valid = 1'b0;
    chk("oor_addr_err", aerr_b, 1);
    chk("oor_busy", busy_b, 0);
    chk("oor_ready", ifb.req_ready, 1);
    chk("oor_enable", en_b, 0);
    cyc(1); chk("oor_addr_err_clear", aerr_b, 0); chk("oor_enable2", en_b, 0);
    ifb.req_valid = 1'b1; ifb.req_addr = 4'd10;
    cyc(1);
    chk("oor10_addr_err", aerr_b, 1);
    ifb.req_addr = 4'd9;
    cyc(1);
    ifb.req_valid = 1'b0;
    chk("in9_addr_err", aerr_b, 0);
    chk("in9_busy", busy_b, 1);
    cyc(1); chk("in9_enable", en_b, 1);
    cyc(3); chk("in9_done", done_b, 1);

`ifdef ROW_SEL_DRV_READBACK_EN
    // faulty decoder: row 9 also driven high during the addr 4 pulse
    cur_a = 4; rb_inject = 1'b1;
    ifa.req_valid = 1'b1; ifa.req_addr = 4'd4;
    cyc(1);
    ifa.req_valid = 1'b0;
    chk("rb_clear_on_accept0", rb_a, 0);
    cyc(3); chk("rb_set", rb_a, 1);
    cyc(1); chk("rb_sticky", rb_a, 1);
    rb_inject = 1'b0;
    ifa.req_valid = 1'b1;
    cyc(1);
    ifa.req_valid = 1'b0;
    chk("rb_clear_on_accept", rb_a, 0);
    cyc(4); chk("rb_clean_access", rb_a, 0); chk("rb_clean_done", done_a, 1);
`endif

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
